// File: rtl/if_pkg.sv
// Shared constants, enums and payload types for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned PC_W    = 12;
    localparam int unsigned INSTR_W = 19;
    localparam int unsigned CNT_W   = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 19'h0;

    typedef enum logic [2:0] {
        PCSRC_SEQ = 3'd0,
        PCSRC_BR  = 3'd1,
        PCSRC_JMP = 3'd2,
        PCSRC_RET = 3'd3
    } pcsrc_e;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // One fetched instruction together with the PC+1 that travels with it.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc1;
    } fetch_word_t;

endpackage

// File: rtl/if_next_pc.sv
// Redirect target mux and +1 incrementer for the fetch stage.
module if_next_pc
    import if_pkg::*;
(
    input  logic [2:0]      pc_src,
    input  logic [PC_W-1:0] id_new_addr,
    input  logic [PC_W-1:0] jmp_addr,
    input  logic [PC_W-1:0] popped_addr,
    input  logic [PC_W-1:0] base,
    output logic            redirect_src,
    output logic [PC_W-1:0] target,
    output logic [PC_W-1:0] base_plus1
);

    // Select the redirect target; codes 4..7 fall back to sequential.
    always_comb begin
        redirect_src = 1'b0;
        target       = base_plus1;
        case (pc_src)
            PCSRC_BR:  begin redirect_src = 1'b1; target = id_new_addr; end
            PCSRC_JMP: begin redirect_src = 1'b1; target = jmp_addr;    end
            PCSRC_RET: begin redirect_src = 1'b1; target = popped_addr; end
            default:   begin redirect_src = 1'b0; target = base_plus1;  end
        endcase
    end

    // Modulo-2^PC_W increment.
    assign base_plus1 = base + PC_W'(1);

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// drives the IF/ID pipeline register. Optional perf counters: IF_PERF_CNT_EN.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 12'h000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IF_ID_Wr,
    input  logic               ldPC,
    input  logic [2:0]         PCSrc,
    input  logic [PC_W-1:0]    IDNewAddr,
    input  logic [PC_W-1:0]    jmpAddr,
    input  logic [PC_W-1:0]    poppedAddr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] instructionOut,
    output logic [PC_W-1:0]    PCPlus1Out,
    output logic               ifIdValid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   fetchCount,
    output logic [CNT_W-1:0]   stallCount
`endif
);

    fetch_state_e       state, state_n;
    logic [PC_W-1:0]    pc, pc_n;
    logic [PC_W-1:0]    req_addr, req_addr_n;
    fetch_word_t        skid, skid_n;
    fetch_word_t        new_word;
    logic               has_new;
    logic [INSTR_W-1:0] instr_n;
    logic [PC_W-1:0]    pc1_n;
    logic               valid_n;
    logic               redirect_src;
    logic               redirect;
    logic [PC_W-1:0]    target;
    logic [PC_W-1:0]    req_plus1;

    if_next_pc u_next_pc (
        .pc_src       (PCSrc),
        .id_new_addr  (IDNewAddr),
        .jmp_addr     (jmpAddr),
        .popped_addr  (poppedAddr),
        .base         (req_addr),
        .redirect_src (redirect_src),
        .target       (target),
        .base_plus1   (req_plus1)
    );

    assign redirect  = ldPC & redirect_src;
    assign imem_req  = ((state == REQ) || (state == DRAIN)) & ~rst;
    assign imem_addr = req_addr;

    // State register, PC, skid buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= REQ;
            pc             <= RESET_PC;
            req_addr       <= RESET_PC;
            skid           <= '0;
            instructionOut <= NOP_INSTR;
            PCPlus1Out     <= '0;
            ifIdValid      <= 1'b0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            req_addr       <= req_addr_n;
            skid           <= skid_n;
            instructionOut <= instr_n;
            PCPlus1Out     <= pc1_n;
            ifIdValid      <= valid_n;
        end
    end

    // Next-state, PC update and IF/ID selection.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        skid_n     = skid;
        has_new    = 1'b0;
        new_word   = '0;
        instr_n    = instructionOut;
        pc1_n      = PCPlus1Out;
        valid_n    = ifIdValid;

        case (state)
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_n       = target;
                        req_addr_n = target;
                    end else if (IF_ID_Wr) begin
                        has_new    = 1'b1;
                        new_word   = '{instr: imem_rdata, pc1: req_plus1};
                        pc_n       = req_plus1;
                        req_addr_n = req_plus1;
                    end else begin
                        skid_n  = '{instr: imem_rdata, pc1: req_plus1};
                        pc_n    = req_plus1;
                        state_n = HOLD;
                    end
                end else if (redirect) begin
                    pc_n    = target;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                // Old request still in flight; its data is dropped on ack.
                if (redirect) pc_n = target;
                if (imem_ack) begin
                    req_addr_n = pc_n;
                    state_n    = REQ;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_n       = target;
                    req_addr_n = target;
                    state_n    = REQ;
                end else if (IF_ID_Wr) begin
                    has_new    = 1'b1;
                    new_word   = skid;
                    req_addr_n = pc;
                    state_n    = REQ;
                end
            end
            default: state_n = REQ;
        endcase

        // IF/ID: redirect bubble > stall hold > new instruction > bubble.
        if (redirect || (IF_ID_Wr && !has_new)) begin
            instr_n = NOP_INSTR;
            pc1_n   = PCPlus1Out;
            valid_n = 1'b0;
        end else if (IF_ID_Wr) begin
            instr_n = new_word.instr;
            pc1_n   = new_word.pc1;
            valid_n = 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic fetch_wr;
    assign fetch_wr = ~redirect & IF_ID_Wr & has_new;

    // Saturating counters of delivered instructions and stalled valid cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchCount <= '0;
            stallCount <= '0;
        end else begin
            if (fetch_wr && (fetchCount != 16'hFFFF))
                fetchCount <= fetchCount + CNT_W'(1);
            if (!IF_ID_Wr && ifIdValid && (stallCount != 16'hFFFF))
                stallCount <= stallCount + CNT_W'(1);
        end
    end
`endif

endmodule
